stack_unit: RTL

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_unit_if.sv | 55 +++++
 rtl/stack_ram.sv | 24 ++
 rtl/stack_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the LIFO stack unit.
// Optional peek support is enabled with STACK_PEEK_EN.
package stack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } stackState_e;

  typedef enum logic [1:0] {
    NOP,
    PUSH,
    POP,
    REPLACE
  } stackOp_e;

endpackage

// File: rtl/stack_unit_if.sv
// Request/response bundle of the stack unit.
// Carries the Peek request only when STACK_PEEK_EN is defined.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
);
  logic             StackWrite;
  logic             StackRead;
  logic             ErrClear;
  logic [WIDTH-1:0] Datain;
  logic [WIDTH-1:0] Dataout;
  logic             DataValid;
  logic             Full;
  logic             Empty;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;
`ifdef STACK_PEEK_EN
  logic             Peek;
`endif

  modport master (
`ifdef STACK_PEEK_EN
    output Peek,
`endif
    output StackWrite,
    output StackRead,
    output ErrClear,
    output Datain,
    input  Dataout,
    input  DataValid,
    input  Full,
    input  Empty,
    input  Count,
    input  Overflow,
    input  Underflow
  );

  modport slave (
`ifdef STACK_PEEK_EN
    input  Peek,
`endif
    input  StackWrite,
    input  StackRead,
    input  ErrClear,
    input  Datain,
    output Dataout,
    output DataValid,
    output Full,
    output Empty,
    output Count,
    output Overflow,
    output Underflow
  );
endinterface

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module stack_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with push/pop/replace, sticky error flags and registered output.
// Define STACK_PEEK_EN to add a non-destructive Peek request.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       Reset,
  stack_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  stackState_e state, stateNxt;
  stackOp_e    op;

  logic [CW-1:0]    sp, spNxt;
  logic [CW-1:0]    count, countNxt;
  logic [WIDTH-1:0] doutQ, doutNxt;
  logic             dvQ, dvNxt;
  logic             ovfQ, unfQ;
  logic             ovfSet, unfSet;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    topIdx;
  logic [WIDTH-1:0] rdata;

  assign topIdx = sp[AW-1:0] - AW'(1);

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) uRam (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.Datain),
    .raddr(topIdx),
    .rdata(rdata)
  );

  always_comb begin
    unique case ({bus.StackWrite, bus.StackRead})
      2'b10:   op = PUSH;
      2'b01:   op = POP;
      2'b11:   op = REPLACE;
      default: op = NOP;
    endcase
  end

  always_comb begin
    stateNxt = state;
    spNxt    = sp;
    countNxt = count;
    doutNxt  = doutQ;
    dvNxt    = 1'b0;
    ovfSet   = 1'b0;
    unfSet   = 1'b0;
    we       = 1'b0;
    waddr    = sp[AW-1:0];
    unique case (op)
      PUSH: begin
        if (state == FULL) begin
          ovfSet = 1'b1;
        end else begin
          we       = 1'b1;
          spNxt    = sp + ONE;
          countNxt = count + ONE;
          if (state == EMPTY) stateNxt = PARTIAL;
          else if (count == LAST) stateNxt = FULL;
        end
      end
      POP: begin
        if (state == EMPTY) begin
          unfSet = 1'b1;
        end else begin
          spNxt    = sp - ONE;
          countNxt = count - ONE;
          doutNxt  = rdata;
          dvNxt    = 1'b1;
          if (state == FULL) stateNxt = PARTIAL;
          else if (count == ONE) stateNxt = EMPTY;
        end
      end
      REPLACE: begin
        if (state == EMPTY) begin
          // Nothing to return: degrade to a plain push and flag it.
          unfSet   = 1'b1;
          we       = 1'b1;
          spNxt    = sp + ONE;
          countNxt = count + ONE;
          stateNxt = PARTIAL;
        end else begin
          we      = 1'b1;
          waddr   = topIdx;
          doutNxt = rdata;
          dvNxt   = 1'b1;
        end
      end
      default: begin
`ifdef STACK_PEEK_EN
        if (bus.Peek) begin
          if (state == EMPTY) begin
            unfSet = 1'b1;
          end else begin
            doutNxt = rdata;
            dvNxt   = 1'b1;
          end
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= EMPTY;
      sp    <= '0;
      count <= '0;
      doutQ <= '0;
      dvQ   <= 1'b0;
      ovfQ  <= 1'b0;
      unfQ  <= 1'b0;
    end else begin
      state <= stateNxt;
      sp    <= spNxt;
      count <= countNxt;
      doutQ <= doutNxt;
      dvQ   <= dvNxt;
      if (bus.ErrClear) begin
        ovfQ <= 1'b0;
        unfQ <= 1'b0;
      end else begin
        ovfQ <= ovfQ | ovfSet;
        unfQ <= unfQ | unfSet;
      end
    end
  end

  assign bus.Dataout   = doutQ;
  assign bus.DataValid = dvQ;
  assign bus.Count     = count;
  assign bus.Full      = (state == FULL);
  assign bus.Empty     = (state == EMPTY);
  assign bus.Overflow  = ovfQ;
  assign bus.Underflow = unfQ;

endmodule
